// File: rtl/bridge_arbiter.sv
// Two-master arbiter and single-outstanding transaction sequencer for the system bridge.
// Define BRIDGE_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 has fixed priority.
module bridge_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_wen,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_wen,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rd,
    output logic        br_wen,
    output logic [31:0] br_addr,
    output logic [31:0] br_wd,
    input  logic [31:0] br_rd,
    input  logic        br_rdy
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

`ifdef BRIDGE_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    logic            state_q,   state_d;
    logic            owner_q,   owner_d;
    logic            last_q,    last_d;
    logic [WD_W-1:0] wdog_q,    wdog_d;
    logic            br_wen_q,  br_wen_d;
    logic [31:0]     br_addr_q, br_addr_d;
    logic [31:0]     br_wd_q,   br_wd_d;
    logic            m0_ack_q,  m0_ack_d;
    logic            m1_ack_q,  m1_ack_d;
    logic            m0_err_q,  m0_err_d;
    logic            m1_err_q,  m1_err_d;
    logic [31:0]     m0_rd_q,   m0_rd_d;
    logic [31:0]     m1_rd_q,   m1_rd_d;
    logic            grant1;

    // last_q is tracked in both builds; it only steers a tie when round-robin is enabled
    always_comb begin
        grant1 = m1_req & (~m0_req | (RR_EN & ~last_q));
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        wdog_d    = wdog_q;
        br_wen_d  = br_wen_q;
        br_addr_d = br_addr_q;
        br_wd_d   = br_wd_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_err_d  = 1'b0;
        m1_err_d  = 1'b0;
        m0_rd_d   = m0_rd_q;
        m1_rd_d   = m1_rd_q;

        case (state_q)
            ST_IDLE: begin
                br_wen_d = 1'b0;
                if (m0_req | m1_req) begin
                    state_d   = ST_BUSY;
                    owner_d   = grant1;
                    wdog_d    = '0;
                    br_wen_d  = grant1 ? m1_wen  : m0_wen;
                    br_addr_d = grant1 ? m1_addr : m0_addr;
                    br_wd_d   = grant1 ? m1_wd   : m0_wd;
                end
            end
            default: begin
                // br_rdy is checked first so completion beats a coincident watchdog expiry
                if (br_rdy) begin
                    state_d  = ST_IDLE;
                    br_wen_d = 1'b0;
                    last_d   = owner_q;
                    if (owner_q) begin
                        m1_ack_d = 1'b1;
                        m1_rd_d  = br_rd;
                    end else begin
                        m0_ack_d = 1'b1;
                        m0_rd_d  = br_rd;
                    end
                end else if (wdog_q == WD_LAST) begin
                    state_d  = ST_IDLE;
                    br_wen_d = 1'b0;
                    last_d   = owner_q;
                    if (owner_q) begin
                        m1_ack_d = 1'b1;
                        m1_err_d = 1'b1;
                        m1_rd_d  = '0;
                    end else begin
                        m0_ack_d = 1'b1;
                        m0_err_d = 1'b1;
                        m0_rd_d  = '0;
                    end
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            wdog_q    <= '0;
            br_wen_q  <= 1'b0;
            br_addr_q <= '0;
            br_wd_q   <= '0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
            m0_rd_q   <= '0;
            m1_rd_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            br_wen_q  <= br_wen_d;
            br_addr_q <= br_addr_d;
            br_wd_q   <= br_wd_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_err_q  <= m0_err_d;
            m1_err_q  <= m1_err_d;
            m0_rd_q   <= m0_rd_d;
            m1_rd_q   <= m1_rd_d;
        end
    end

    assign m0_ack  = m0_ack_q;
    assign m1_ack  = m1_ack_q;
    assign m0_err  = m0_err_q;
    assign m1_err  = m1_err_q;
    assign m0_rd   = m0_rd_q;
    assign m1_rd   = m1_rd_q;
    assign br_wen  = br_wen_q;
    assign br_addr = br_addr_q;
    assign br_wd   = br_wd_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed self-checking bench for bridge_arbiter, built with TIMEOUT = 4.
module tb_bridge_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_wen, m1_req, m1_wen;
    logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic        br_wen, br_rdy;
    logic [31:0] br_addr, br_wd, br_rd;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    bridge_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd(m1_rd),
        .br_wen(br_wen), .br_addr(br_addr), .br_wd(br_wd),
        .br_rd(br_rd), .br_rdy(br_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " m0_ack"}, {31'd0, m0_ack}, 32'd0);
        check({tag, " m1_ack"}, {31'd0, m1_ack}, 32'd0);
        check({tag, " m0_err"}, {31'd0, m0_err}, 32'd0);
        check({tag, " m1_err"}, {31'd0, m1_err}, 32'd0);
        check({tag, " br_wen"}, {31'd0, br_wen}, 32'd0);
        check({tag, " br_addr"}, br_addr, 32'd0);
        check({tag, " br_wd"}, br_wd, 32'd0);
        check({tag, " m0_rd"}, m0_rd, 32'd0);
        check({tag, " m1_rd"}, m1_rd, 32'd0);
    endtask

    logic exp_m1;

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_wen = 0; m0_addr = '0; m0_wd = '0;
        m1_req = 0; m1_wen = 0; m1_addr = '0; m1_wd = '0;
        br_rd = '0; br_rdy = 0;

        // Reset state
        step(); step();
        check_idle_outputs("reset");
        #3 rst_n = 1'b1;
        step();
        check_idle_outputs("post_reset");

        // Single read by m0, device ready on first BUSY cycle
        m0_req = 1; m0_wen = 0; m0_addr = 32'h0000_7F04;
        br_rd = 32'hDEAD_BEEF; br_rdy = 1;
        step();
        check("rd busy br_addr", br_addr, 32'h0000_7F04);
        check("rd busy br_wen", {31'd0, br_wen}, 32'd0);
        check("rd busy m0_ack", {31'd0, m0_ack}, 32'd0);
        step();
        check("rd m0_ack", {31'd0, m0_ack}, 32'd1);
        check("rd m0_err", {31'd0, m0_err}, 32'd0);
        check("rd m0_rd", m0_rd, 32'hDEAD_BEEF);
        check("rd m1_ack", {31'd0, m1_ack}, 32'd0);
        m0_req = 0; br_rdy = 0;
        step();
        check("rd ack pulse", {31'd0, m0_ack}, 32'd0);

        // Write hold by m1; ready arrives on BUSY cycle 4, where the watchdog also hits TIMEOUT-1
        m1_req = 1; m1_wen = 1; m1_addr = 32'h0000_7F10; m1_wd = 32'h0000_1234;
        br_rd = 32'hA5A5_0001;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wr br_wd", br_wd, 32'h0000_1234);
            check("wr br_wen", {31'd0, br_wen}, 32'd1);
            check("wr br_addr", br_addr, 32'h0000_7F10);
            check("wr early ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            m1_wd = 32'h0000_5678;
        end
        br_rdy = 1;
        step();
        check("wr m1_ack", {31'd0, m1_ack}, 32'd1);
        check("wr collision err", {31'd0, m1_err}, 32'd0);
        check("wr m1_rd", m1_rd, 32'hA5A5_0001);
        check("wr br_wen cleared", {31'd0, br_wen}, 32'd0);
        check("wr m0_rd held", m0_rd, 32'hDEAD_BEEF);
        m1_req = 0; br_rdy = 0;
        step();
        check("wr single ack", {31'd0, m1_ack}, 32'd0);

        // Timeout: m0 read with no ready; abort after 4 BUSY cycles
        m0_req = 1; m0_wen = 0; m0_addr = 32'h0000_0100; br_rd = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("to waiting ack", {31'd0, m0_ack}, 32'd0);
        end
        step();
        check("to m0_ack", {31'd0, m0_ack}, 32'd1);
        check("to m0_err", {31'd0, m0_err}, 32'd1);
        check("to m0_rd", m0_rd, 32'd0);
        check("to m1_rd held", m1_rd, 32'hA5A5_0001);
        check("to m1_ack", {31'd0, m1_ack}, 32'd0);
        m0_req = 0;
        m1_req = 1; m1_wen = 0; m1_addr = 32'h0000_0200; br_rd = 32'h0BAD_F00D; br_rdy = 1;
        step();
        check("to err pulse", {31'd0, m0_err}, 32'd0);
        check("after to br_addr", br_addr, 32'h0000_0200);
        step();
        check("after to m1_ack", {31'd0, m1_ack}, 32'd1);
        check("after to m1_err", {31'd0, m1_err}, 32'd0);
        check("after to m1_rd", m1_rd, 32'h0BAD_F00D);
        m1_req = 0; br_rdy = 0;
        step();

        // Collision on a read: ready coincides with watchdog reaching TIMEOUT-1
        m0_req = 1; m0_addr = 32'h0000_0300; br_rd = 32'hC0DE_0004;
        step(); step(); step(); step();
        check("col pre ack", {31'd0, m0_ack}, 32'd0);
        br_rdy = 1;
        step();
        check("col m0_ack", {31'd0, m0_ack}, 32'd1);
        check("col m0_err", {31'd0, m0_err}, 32'd0);
        check("col m0_rd", m0_rd, 32'hC0DE_0004);
        m0_req = 0; br_rdy = 0;
        step();

        // Reset mid-BUSY during an m1 write
        m1_req = 1; m1_wen = 1; m1_addr = 32'h0000_7F20; m1_wd = 32'h0000_55AA;
        step();
        check("rst busy br_wen", {31'd0, br_wen}, 32'd1);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset");
        #2 rst_n = 1'b1;
        m1_req = 0; m1_wen = 0;
        step();
        check("rst no ack m1", {31'd0, m1_ack}, 32'd0);
        check("rst idle br_wen", {31'd0, br_wen}, 32'd0);
        step();
        check("rst still no ack", {31'd0, m1_ack}, 32'd0);

        // Tie after reset: both request continuously, device always ready
        m0_req = 1; m0_wen = 0; m0_addr = 32'h0000_0A00;
        m1_req = 1; m1_wen = 0; m1_addr = 32'h0000_0B00;
        br_rd = 32'h1111_2222; br_rdy = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef BRIDGE_ARB_RR_EN
            exp_m1 = (i % 2) == 1;
`else
            exp_m1 = 1'b0;
`endif
            step();
            check("tie busy addr", br_addr, exp_m1 ? 32'h0000_0B00 : 32'h0000_0A00);
            step();
            check("tie m0_ack", {31'd0, m0_ack}, {31'd0, ~exp_m1});
            check("tie m1_ack", {31'd0, m1_ack}, {31'd0, exp_m1});
        end
        m0_req = 0; m1_req = 0; br_rdy = 0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Two-master arbiter and transaction sequencer for the system bridge. It shares the bridge's single processor-side port between the CPU data port (master 0) and a DMA/debug master (master 1). It registers one transaction at a time, holds the bridge inputs stable until the addressed device signals completion, and returns the read data plus a one-cycle acknowledge to the winning master. A watchdog ends any transaction whose device never responds.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum BUSY cycles before a transaction is aborted. Legal range 2..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `m0_req`, `m1_req`  in  1  transaction request; held high until the matching ack.
- `m0_wen`, `m1_wen`  in  1  1 = write, 0 = read.
- `m0_addr`, `m1_addr`  in  32  byte address, passed to the bridge unchanged.
- `m0_wd`, `m1_wd`  in  32  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  one-cycle pulse coincident with ack when the transaction timed out.
- `m0_rd`, `m1_rd`  out  32  registered read data, valid in the ack cycle and held until the next ack to that master.
- `br_wen`  out  1  write strobe to the bridge.
- `br_addr`  out  32  address to the bridge.
- `br_wd`  out  32  write data to the bridge.
- `br_rd`  in  32  read data from the bridge.
- `br_rdy`  in  1  device completion, sampled only in BUSY.

## Operation
- States: IDLE, BUSY.
- Reset state:
  - State IDLE.
  - All ack/err outputs 0.
  - `br_wen`, `br_addr`, `br_wd` are 0.
  - `m0_rd`, `m1_rd` are 0.
  - Owner register is 0.
  - Watchdog is 0.
  - `last` is 1.
- IDLE:
  - If any request is high, pick a winner and move to BUSY.
  - Latch the winner's addr, wd and wen into the `br_*` registers.
  - Set the owner register and clear the watchdog.
  - With no request, stay in IDLE and drive `br_wen` = 0.
- BUSY, `br_rdy` = 1:
  - Capture `br_rd` into `mX_rd` of the owner.
  - Pulse the owner's ack and return to IDLE.
  - Clear `br_wen` and set `last` = owner.
- BUSY, `br_rdy` = 0:
  - Increment the watchdog.
  - When the watchdog reaches `TIMEOUT-1`: pulse owner ack and err, load 0 into the owner's `mX_rd`, return to IDLE, set `last` = owner.
- Write semantics:
  - `br_wen` is high for every BUSY cycle of a write, so devices may sample it on any cycle.
  - A device must act on the write only once.
- Request timing:
  - Requests are sampled only in IDLE.
  - Changes to the owner's addr/wd/wen during BUSY are ignored.
  - The owner dropping req during BUSY does not abort the transaction; the ack is still issued.
- The non-owner's ack, err and rd never change.
- Watchdog width is `$clog2(TIMEOUT)`.

## Timing
- Request seen at edge N (IDLE):
  - BUSY with `br_*` valid after edge N.
  - `br_rdy` high during cycle N+1 gives the ack in cycle N+2.
  - Minimum latency from req to ack is 2 cycles.
- Master handshake: a master sees ack, then must drop req or present a new transaction the same cycle. A req still high in the ack cycle is taken as a new request at the next IDLE edge.
- There is always exactly one IDLE cycle between back-to-back transactions.
- Simultaneous `br_rdy` and watchdog expiry: `br_rdy` wins; normal ack, no err.
- `rst_n` low mid-BUSY:
  - Immediate return to IDLE with all outputs at reset values.
  - No ack is issued for the aborted transaction.

## Configuration
- `BRIDGE_ARB_RR_EN` defined: round-robin arbitration. When both masters request in IDLE, grant the master that is not `last`. A single requester always wins.
- Not defined: fixed priority, master 0 always wins a tie.
- The `last` register is updated in both builds. It only affects arbitration when the macro is defined.

## Test plan
- Single read:
  - Stimulus: m0 reads 0x7F04; the bench holds `br_rd` = 0xDEADBEEF and raises `br_rdy` on the first BUSY cycle.
  - Response: `m0_ack` 2 cycles after req, `m0_rd` = 0xDEADBEEF, `m1_ack` stays 0.
- Write hold:
  - Stimulus: m1 writes 0x1234 to 0x7F10; `br_rdy` is delayed 3 cycles; m1 changes `m1_wd` to 0x5678 mid-BUSY.
  - Response: `br_wd` stays 0x1234 and `br_wen` stays high for all 4 BUSY cycles; one `m1_ack`.
- Tie:
  - Stimulus: both masters request continuously, `br_rdy` = 1 every cycle.
  - Response, with `BRIDGE_ARB_RR_EN`: grants alternate 0,1,0,1.
  - Response, without it: only m0 is granted.
- Timeout:
  - Stimulus: `TIMEOUT` = 4, m0 reads, `br_rdy` held 0.
  - Response: `m0_ack` and `m0_err` pulse together, `m0_rd` = 0, then IDLE; a following m1 request completes normally.
- Collision:
  - Stimulus: `br_rdy` rises in the same cycle the watchdog reaches `TIMEOUT-1`.
  - Response: ack with `err` = 0 and `rd` = `br_rd`.
- Reset mid-BUSY:
  - Stimulus: pulse `rst_n` low mid-BUSY.
  - Response: outputs go to 0 asynchronously, no ack, state IDLE; a subsequent tie is granted to m0.
